alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 52 +++++
 rtl/alu_seq_if.sv | 41 ++++
 rtl/alu_seq_ret_stack.sv | 44 ++++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq instruction sequencer.
// The instruction word layout and the ctrl encodings live here so every file agrees on them.
package alu_seq_pkg;

    localparam int WIDTH        = 8;
    localparam int IWIDTH       = 8;
    localparam int SOURCES      = 4;
    localparam int CHOICE_WIDTH = $clog2(SOURCES);
    localparam int ADDR_WIDTH   = 8;
    localparam int PC_WIDTH     = 6;
    localparam int STACK_DEPTH  = 4;
    localparam int INSTR_WIDTH  = 41;

    localparam int OP_MSB    = 40;
    localparam int OP_LSB    = 33;
    localparam int SRC1C_MSB = 32;
    localparam int SRC1C_LSB = 31;
    localparam int SRC2C_MSB = 30;
    localparam int SRC2C_LSB = 29;
    localparam int DESTC_MSB = 28;
    localparam int DESTC_LSB = 27;
    localparam int CTRL_MSB  = 26;
    localparam int CTRL_LSB  = 24;
    localparam int SRC1_MSB  = 23;
    localparam int SRC1_LSB  = 16;
    localparam int SRC2_MSB  = 15;
    localparam int SRC2_LSB  = 8;
    localparam int DEST_MSB  = 7;
    localparam int DEST_LSB  = 0;

    // dest_choice value the datapath treats as "write nothing"
    localparam logic [CHOICE_WIDTH-1:0] DEST_NONE = {CHOICE_WIDTH{1'b1}};

    localparam logic [2:0] CTRL_EXEC = 3'b000;
    localparam logic [2:0] CTRL_JMP  = 3'b001;
    localparam logic [2:0] CTRL_JZ   = 3'b010;
    localparam logic [2:0] CTRL_JNZ  = 3'b011;
    localparam logic [2:0] CTRL_CALL = 3'b100;
    localparam logic [2:0] CTRL_RET  = 3'b101;
    localparam logic [2:0] CTRL_HALT = 3'b110;
    localparam logic [2:0] CTRL_NOP  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT,
        FAULT
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Bundle of the sequencer's control, instruction-fetch and datapath-control signals.
// The master modport is the sequencer; the slave modport is memory plus datapath.
interface alu_seq_if;
    import alu_seq_pkg::*;

    logic                    start;
    logic [PC_WIDTH-1:0]     imem_addr;
    logic                    imem_req;
    logic                    imem_valid;
    logic [INSTR_WIDTH-1:0]  imem_data;
    logic [IWIDTH-1:0]       op_code;
    logic [ADDR_WIDTH-1:0]   source1;
    logic [ADDR_WIDTH-1:0]   source2;
    logic [ADDR_WIDTH-1:0]   destination;
    logic [CHOICE_WIDTH-1:0] source1_choice;
    logic [CHOICE_WIDTH-1:0] source2_choice;
    logic [CHOICE_WIDTH-1:0] dest_choice;
    logic                    push;
    logic                    pop;
    logic [PC_WIDTH-1:0]     instr_addr;
    logic                    zero_flag;
    logic                    flag_rst;
    logic                    busy;
    logic                    halted;
    logic                    fault;

    modport master (
        input  start, imem_valid, imem_data, zero_flag,
        output imem_addr, imem_req, op_code, source1, source2, destination,
               source1_choice, source2_choice, dest_choice, push, pop,
               instr_addr, flag_rst, busy, halted, fault
    );

    modport slave (
        output start, imem_valid, imem_data, zero_flag,
        input  imem_addr, imem_req, op_code, source1, source2, destination,
               source1_choice, source2_choice, dest_choice, push, pop,
               instr_addr, flag_rst, busy, halted, fault
    );

endinterface

// File: rtl/alu_seq_ret_stack.sv
// Return-address stack for CALL/RET: DEPTH entries of WIDTH bits, with full/empty status.
// The caller must not push when full or pop when empty.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_WIDTH = $clog2(DEPTH + 1);
    localparam int IDX_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] sp;
    logic [IDX_WIDTH-1:0] wr_idx;
    logic [IDX_WIDTH-1:0] top_idx;

    assign wr_idx   = sp[IDX_WIDTH-1:0];
    assign top_idx  = wr_idx - IDX_WIDTH'(1);
    assign top_data = mem[top_idx];
    assign full     = (sp == PTR_WIDTH'(DEPTH));
    assign empty    = (sp == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            sp          <= sp + PTR_WIDTH'(1);
        end else if (pop && !empty) begin
            sp <= sp - PTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Instruction sequencer: fetches 41-bit words, presents their fields to the datapath over
// DECODE/EXEC, and resolves jumps, calls, returns, halt and fault.
module alu_seq
    import alu_seq_pkg::*;
(
    input logic       clk,
    input logic       rst,
    alu_seq_if.master bus
);
    state_t                  state, state_next;
    logic [PC_WIDTH-1:0]     pc, pc_next, pc_inc, jump_pc, ret_addr;
    logic [INSTR_WIDTH-1:0]  ir;
    logic [2:0]              ctrl;
    logic [ADDR_WIDTH-1:0]   ir_dest;
    logic                    flag_rst_q;
    logic                    stack_push, stack_pop, stack_full, stack_empty;

    assign ctrl    = ir[CTRL_MSB:CTRL_LSB];
    assign ir_dest = ir[DEST_MSB:DEST_LSB];
    assign jump_pc = ir_dest[PC_WIDTH-1:0];
    assign pc_inc  = pc + PC_WIDTH'(1);

    assign bus.push       = stack_push;
    assign bus.pop        = stack_pop;
    assign bus.instr_addr = pc;
    assign bus.flag_rst   = flag_rst_q;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (pc_inc),
        .top_data  (ret_addr),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // flag_rst rests high in reset and pulses for the first FETCH cycle after a restart from HALT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= '0;
            ir         <= '0;
            flag_rst_q <= 1'b1;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            flag_rst_q <= (state == HALT) && bus.start;
            if (state == FETCH && bus.imem_valid) begin
                ir <= bus.imem_data;
            end
        end
    end

    always_comb begin
        state_next         = state;
        pc_next            = pc;
        stack_push         = 1'b0;
        stack_pop          = 1'b0;
        bus.imem_req       = 1'b0;
        bus.imem_addr      = '0;
        bus.op_code        = '0;
        bus.source1        = '0;
        bus.source2        = '0;
        bus.destination    = '0;
        bus.source1_choice = '0;
        bus.source2_choice = '0;
        bus.dest_choice    = DEST_NONE;
        bus.busy           = 1'b0;
        bus.halted         = 1'b0;
        bus.fault          = 1'b0;

        if (state == DECODE || state == EXEC) begin
            bus.op_code        = ir[OP_MSB:OP_LSB];
            bus.source1        = ir[SRC1_MSB:SRC1_LSB];
            bus.source2        = ir[SRC2_MSB:SRC2_LSB];
            bus.destination    = ir_dest;
            bus.source1_choice = ir[SRC1C_MSB:SRC1C_LSB];
            bus.source2_choice = ir[SRC2C_MSB:SRC2C_LSB];
        end

        case (state)
            IDLE: begin
                if (bus.start) state_next = FETCH;
            end
            FETCH: begin
                bus.busy      = 1'b1;
                bus.imem_req  = 1'b1;
                bus.imem_addr = pc;
                if (bus.imem_valid) state_next = DECODE;
            end
            DECODE: begin
                bus.busy   = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                bus.busy   = 1'b1;
                state_next = FETCH;
                pc_next    = pc_inc;
                case (ctrl)
                    CTRL_EXEC: bus.dest_choice = ir[DESTC_MSB:DESTC_LSB];
                    CTRL_JMP:  pc_next = jump_pc;
                    CTRL_JZ:   if (bus.zero_flag)  pc_next = jump_pc;
                    CTRL_JNZ:  if (!bus.zero_flag) pc_next = jump_pc;
                    CTRL_CALL: begin
                        if (stack_full) begin
                            state_next = FAULT;
                            pc_next    = pc;
                        end else begin
                            stack_push = 1'b1;
                            pc_next    = jump_pc;
                        end
                    end
                    CTRL_RET: begin
                        if (stack_empty) begin
                            state_next = FAULT;
                            pc_next    = pc;
                        end else begin
                            stack_pop = 1'b1;
                            pc_next   = ret_addr;
                        end
                    end
                    CTRL_HALT: state_next = HALT;
                    default: ;
                endcase
            end
            HALT: begin
                bus.halted = 1'b1;
                if (bus.start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            FAULT: begin
                bus.fault = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a directed vector table, randomized programs against a
// queue-based reference model, and hand-built sequences for stack, halt, fault and reset cases.
module tb_alu_seq;

    localparam logic [2:0] C_EXEC = 3'd0, C_JMP = 3'd1, C_JZ = 3'd2, C_JNZ = 3'd3,
                           C_CALL = 3'd4, C_RET = 3'd5, C_HALT = 3'd6, C_NOP = 3'd7;
    localparam int M_FETCH = 0, M_HALT = 1, M_FAULT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if bus();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int model_pc = 0;
    int ret_q[$];

    typedef struct {
        logic [2:0] ctrl;
        logic [1:0] dc;
        logic [7:0] dest;
        logic [7:0] op;
        logic       zf;
        int         waitc;
        logic [5:0] exp_pc;
        logic       exp_push;
        logic       exp_pop;
    } vec_t;

    vec_t vecs[12];
    logic [2:0] ctrl_set[7];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [40:0] make_word(input logic [7:0] op, input logic [1:0] c1,
                                              input logic [1:0] c2, input logic [1:0] dc,
                                              input logic [2:0] ctrl, input logic [7:0] s1,
                                              input logic [7:0] s2, input logic [7:0] dest);
        return {op, c1, c2, dc, ctrl, s1, s2, dest};
    endfunction

    // Reference model: next pc and stack strobes from the ctrl code rules
    task automatic model_step(input logic [2:0] ctrl, input logic [7:0] dest, input logic zf,
                              output logic [5:0] npc, output logic epush, output logic epop);
        int nxt;
        nxt   = (model_pc + 1) % 64;
        epush = 1'b0;
        epop  = 1'b0;
        case (ctrl)
            C_JMP:  nxt = dest % 64;
            C_JZ:   if (zf)  nxt = dest % 64;
            C_JNZ:  if (!zf) nxt = dest % 64;
            C_CALL: begin ret_q.push_back((model_pc + 1) % 64); epush = 1'b1; nxt = dest % 64; end
            C_RET:  begin nxt = ret_q.pop_back(); epop = 1'b1; end
            default: ;
        endcase
        npc = 6'(nxt);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_output("rst_dest_choice", bus.dest_choice, 2'b11);
        check_output("rst_flag_rst", bus.flag_rst, 1'b1);
        check_output("rst_instr_addr", bus.instr_addr, 6'd0);
        check_output("rst_busy", bus.busy, 1'b0);
        check_output("rst_imem_req", bus.imem_req, 1'b0);
        check_output("rst_push_pop", {bus.push, bus.pop}, 2'b00);
        check_output("rst_op_code", bus.op_code, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("rst_flag_release", bus.flag_rst, 1'b0);
        check_output("rst_idle_busy", bus.busy, 1'b0);
        model_pc = 0;
        ret_q.delete();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_output("start_busy", bus.busy, 1'b1);
    endtask

    // Entered at a negedge with the DUT in FETCH; runs one instruction and checks every stage
    task automatic apply_stimulus(input logic [40:0] word, input int waitc, input logic zf,
                                  input logic [5:0] exp_pc, input logic exp_push,
                                  input logic exp_pop, input int exp_mode);
        logic [2:0]  ctrl;
        logic [1:0]  dc_exp;
        logic [63:0] junk;
        ctrl   = word[26:24];
        dc_exp = (ctrl == C_EXEC) ? word[28:27] : 2'b11;
        check_output("fetch_req", bus.imem_req, 1'b1);
        check_output("fetch_addr", bus.imem_addr, model_pc[5:0]);
        for (int w = 0; w < waitc; w++) begin
            bus.imem_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_output("wait_req_held", bus.imem_req, 1'b1);
            check_output("wait_busy", bus.busy, 1'b1);
            check_output("wait_no_write", bus.dest_choice, 2'b11);
        end
        bus.imem_valid = 1'b1;
        bus.imem_data  = word;
        @(posedge clk);
        @(negedge clk);
        junk           = {$urandom, $urandom};
        bus.imem_data  = junk[40:0];
        bus.zero_flag  = zf;
        check_output("decode_dest_choice", bus.dest_choice, 2'b11);
        check_output("decode_op_code", bus.op_code, word[40:33]);
        check_output("decode_source1", bus.source1, word[23:16]);
        check_output("decode_strobes", {bus.push, bus.pop}, 2'b00);
        check_output("decode_busy", bus.busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        check_output("exec_dest_choice", bus.dest_choice, dc_exp);
        check_output("exec_op_code", bus.op_code, word[40:33]);
        check_output("exec_choices", {bus.source1_choice, bus.source2_choice}, word[32:29]);
        check_output("exec_source2", bus.source2, word[15:8]);
        check_output("exec_destination", bus.destination, word[7:0]);
        check_output("exec_push", bus.push, exp_push);
        check_output("exec_pop", bus.pop, exp_pop);
        @(posedge clk);
        @(negedge clk);
        check_output("next_pc", bus.instr_addr, exp_pc);
        case (exp_mode)
            M_FETCH: begin
                check_output("next_fetch_req", bus.imem_req, 1'b1);
                check_output("next_fetch_addr", bus.imem_addr, exp_pc);
            end
            M_HALT: check_output("next_halted", {bus.halted, bus.busy}, 2'b10);
            default: begin
                check_output("next_fault", {bus.fault, bus.busy}, 2'b10);
                check_output("next_fault_req", bus.imem_req, 1'b0);
            end
        endcase
        model_pc = int'(exp_pc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] npc;
        logic       ep, eo;
        logic [2:0] ctrl;
        logic [7:0] dest;
        logic       zf;

        bus.start      = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_data  = '0;
        bus.zero_flag  = 1'b0;
        ctrl_set = '{C_EXEC, C_JMP, C_JZ, C_JNZ, C_CALL, C_RET, C_NOP};

        //            ctrl    dc     dest   op     zf    wait exp_pc push  pop
        vecs[0]  = '{C_EXEC, 2'd0, 8'h03, 8'h5A, 1'b0, 1, 6'h01, 1'b0, 1'b0};
        vecs[1]  = '{C_EXEC, 2'd1, 8'h44, 8'h11, 1'b0, 5, 6'h02, 1'b0, 1'b0};
        vecs[2]  = '{C_JZ,   2'd0, 8'h20, 8'h22, 1'b1, 0, 6'h20, 1'b0, 1'b0};
        vecs[3]  = '{C_JZ,   2'd0, 8'h05, 8'h23, 1'b0, 0, 6'h21, 1'b0, 1'b0};
        vecs[4]  = '{C_JNZ,  2'd2, 8'h3F, 8'h24, 1'b1, 0, 6'h22, 1'b0, 1'b0};
        vecs[5]  = '{C_JMP,  2'd0, 8'hFF, 8'h25, 1'b0, 2, 6'h3F, 1'b0, 1'b0};
        vecs[6]  = '{C_NOP,  2'd1, 8'h07, 8'h26, 1'b0, 0, 6'h00, 1'b0, 1'b0};
        vecs[7]  = '{C_JNZ,  2'd0, 8'h05, 8'h27, 1'b0, 0, 6'h05, 1'b0, 1'b0};
        vecs[8]  = '{C_CALL, 2'd0, 8'h10, 8'h28, 1'b0, 1, 6'h10, 1'b1, 1'b0};
        vecs[9]  = '{C_EXEC, 2'd2, 8'h07, 8'h29, 1'b0, 0, 6'h11, 1'b0, 1'b0};
        vecs[10] = '{C_RET,  2'd0, 8'h00, 8'h2A, 1'b0, 0, 6'h06, 1'b0, 1'b1};
        vecs[11] = '{C_JZ,   2'd3, 8'h30, 8'h2B, 1'b1, 2, 6'h30, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();
        do_start();

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(make_word(vecs[i].op, 2'(i), 2'(i + 1), vecs[i].dc, vecs[i].ctrl,
                                     8'(i * 3), 8'(i * 5), vecs[i].dest),
                           vecs[i].waitc, vecs[i].zf, vecs[i].exp_pc,
                           vecs[i].exp_push, vecs[i].exp_pop, M_FETCH);
        end

        // Random programs; start held high to show it is ignored while busy
        bus.start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ctrl = ctrl_set[$urandom_range(0, 6)];
            if (ctrl == C_CALL && ret_q.size() == 4) ctrl = C_EXEC;
            if (ctrl == C_RET && ret_q.size() == 0) ctrl = C_NOP;
            dest = 8'($urandom);
            zf   = 1'($urandom);
            model_step(ctrl, dest, zf, npc, ep, eo);
            apply_stimulus(make_word(8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                                     ctrl, 8'($urandom), 8'($urandom), dest),
                           $urandom_range(0, 3), zf, npc, ep, eo, M_FETCH);
        end
        bus.start = 1'b0;

        // Four nested calls fill the stack; the fifth must fault without pushing
        do_reset();
        do_start();
        for (int k = 1; k <= 4; k++) begin
            dest = 8'(k * 8);
            model_step(C_CALL, dest, 1'b0, npc, ep, eo);
            apply_stimulus(make_word(8'h40, 2'd0, 2'd1, 2'd0, C_CALL, 8'h01, 8'h02, dest),
                           0, 1'b0, npc, ep, eo, M_FETCH);
        end
        apply_stimulus(make_word(8'h40, 2'd0, 2'd1, 2'd0, C_CALL, 8'h01, 8'h02, 8'h28),
                       1, 1'b0, 6'h20, 1'b0, 1'b0, M_FAULT);
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("fault_sticky", {bus.fault, bus.busy, bus.push}, 3'b100);
        end
        bus.start = 1'b0;

        // Return with nothing on the stack
        do_reset();
        do_start();
        apply_stimulus(make_word(8'h50, 2'd1, 2'd2, 2'd0, C_RET, 8'h03, 8'h04, 8'h09),
                       0, 1'b0, 6'h00, 1'b0, 1'b0, M_FAULT);

        // Halt, then restart from pc 0 with a one-cycle flag reset
        do_reset();
        do_start();
        apply_stimulus(make_word(8'h60, 2'd0, 2'd0, 2'd0, C_JMP, 8'h00, 8'h00, 8'h2A),
                       0, 1'b0, 6'h2A, 1'b0, 1'b0, M_FETCH);
        apply_stimulus(make_word(8'h61, 2'd0, 2'd0, 2'd0, C_HALT, 8'h00, 8'h00, 8'h00),
                       0, 1'b0, 6'h2B, 1'b0, 1'b0, M_HALT);
        @(posedge clk);
        @(negedge clk);
        check_output("halt_stays", {bus.halted, bus.flag_rst}, 2'b10);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_output("restart_pc", bus.instr_addr, 6'h00);
        check_output("restart_flag_rst", bus.flag_rst, 1'b1);
        check_output("restart_fetch", {bus.imem_req, bus.halted}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        check_output("restart_flag_pulse", bus.flag_rst, 1'b0);
        model_pc = 0;

        // Reset arriving in the middle of an EXEC cycle
        do_reset();
        do_start();
        apply_stimulus(make_word(8'h70, 2'd0, 2'd0, 2'd0, C_JMP, 8'h00, 8'h00, 8'h15),
                       0, 1'b0, 6'h15, 1'b0, 1'b0, M_FETCH);
        bus.imem_valid = 1'b1;
        bus.imem_data  = make_word(8'h71, 2'd1, 2'd1, 2'd0, C_EXEC, 8'h01, 8'h02, 8'h03);
        @(posedge clk);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("midexec_write", bus.dest_choice, 2'b00);
        #2;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
